// File: rtl/vadd_sched_pkg.sv
// Shared types for the vector-add command scheduler.
// Command fields are stored at their widest so any parameterisation fits.
package vadd_sched_pkg;

    localparam int CMD_ADDR_W = 32;
    localparam int CMD_LEN_W  = 32;
    localparam int CMD_TAG_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        CPL
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK    = 2'd0,
        ERR_LEN0  = 2'd1,
        ERR_RANGE = 2'd2,
        ERR_RSVD  = 2'd3
    } err_t;

    typedef struct packed {
        logic [CMD_ADDR_W-1:0] addr_a;
        logic [CMD_ADDR_W-1:0] addr_b;
        logic [CMD_ADDR_W-1:0] addr_out;
        logic [CMD_LEN_W-1:0]  len;
        logic [CMD_TAG_W-1:0]  tag;
    } cmd_t;

    // 33-bit sum so a vector ending past the top of BRAM cannot wrap
    function automatic logic over_range(
        input logic [CMD_ADDR_W-1:0] base,
        input logic [CMD_LEN_W-1:0]  len,
        input int unsigned           aw
    );
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, base} + {1'b0, len};
        lim = 33'd1 << aw;
        return sum > lim;
    endfunction

endpackage

// File: rtl/sched_cmd_fifo.sv
// Power-of-two circular command queue with occupancy count.
// Pointers wrap naturally at DEPTH; push when full is dropped.
module sched_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/vadd_cmd_sched.sv
// Queues vector-add commands and issues them one at a time to the engine,
// rejecting zero-length or out-of-range commands without starting it.
module vadd_cmd_sched
    import vadd_sched_pkg::*;
#(
    parameter int ADDR_WIDTH = 13,
    parameter int DEPTH      = 4,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_a,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_b,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_out,
    input  logic [31:0]             cmd_len,
    input  logic [TAG_WIDTH-1:0]    cmd_tag,
    output logic                    eng_start,
    output logic [ADDR_WIDTH-1:0]   eng_addr_a,
    output logic [ADDR_WIDTH-1:0]   eng_addr_b,
    output logic [ADDR_WIDTH-1:0]   eng_addr_out,
    output logic [31:0]             eng_len,
    input  logic                    eng_done,
    output logic                    cpl_valid,
    input  logic                    cpl_ready,
    output logic [TAG_WIDTH-1:0]    cpl_tag,
    output logic [1:0]              cpl_err,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  count
);

    cmd_t                 cmd_in;
    cmd_t                 head;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 empty;
    state_t               state_q;
    state_t               state_d;
    err_t                 head_err;
    err_t                 err_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic                 unused_tag;

    always_comb begin
        cmd_in          = '0;
        cmd_in.addr_a   = CMD_ADDR_W'(cmd_addr_a);
        cmd_in.addr_b   = CMD_ADDR_W'(cmd_addr_b);
        cmd_in.addr_out = CMD_ADDR_W'(cmd_addr_out);
        cmd_in.len      = cmd_len;
        cmd_in.tag      = CMD_TAG_W'(cmd_tag);
    end

    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready;

    sched_cmd_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (cmd_in),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign unused_tag = ^head.tag;

    // zero length wins over a range violation
    always_comb begin
        head_err = ERR_OK;
        if (head.len == '0) begin
            head_err = ERR_LEN0;
        end else if (over_range(head.addr_a, head.len, ADDR_WIDTH) ||
                     over_range(head.addr_b, head.len, ADDR_WIDTH) ||
                     over_range(head.addr_out, head.len, ADDR_WIDTH)) begin
            head_err = ERR_RANGE;
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = (head_err == ERR_OK) ? ISSUE : CPL;
                end
            end
            ISSUE:     state_d = WAIT_DONE;
            WAIT_DONE: if (eng_done) state_d = CPL;
            CPL:       if (cpl_ready) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            eng_start    <= 1'b0;
            eng_addr_a   <= '0;
            eng_addr_b   <= '0;
            eng_addr_out <= '0;
            eng_len      <= '0;
            tag_q        <= '0;
            err_q        <= ERR_OK;
        end else begin
            state_q   <= state_d;
            eng_start <= (state_q == ISSUE);
            if (pop) begin
                eng_addr_a   <= head.addr_a[ADDR_WIDTH-1:0];
                eng_addr_b   <= head.addr_b[ADDR_WIDTH-1:0];
                eng_addr_out <= head.addr_out[ADDR_WIDTH-1:0];
                eng_len      <= head.len;
                tag_q        <= head.tag[TAG_WIDTH-1:0];
                err_q        <= head_err;
            end else if (state_q == WAIT_DONE && eng_done) begin
                err_q <= ERR_OK;
            end
        end
    end

    assign cpl_valid = (state_q == CPL);
    assign cpl_tag   = tag_q;
    assign cpl_err   = err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_vadd_cmd_sched.sv
// Scoreboard bench for vadd_cmd_sched: directed commands push expected
// engine starts and completions; negedge monitors pop and compare.
module tb_vadd_cmd_sched;

    localparam int AW = 13;
    localparam int D  = 4;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr_a = '0;
    logic [AW-1:0] cmd_addr_b = '0;
    logic [AW-1:0] cmd_addr_out = '0;
    logic [31:0]   cmd_len = '0;
    logic [TW-1:0] cmd_tag = '0;
    logic          eng_start;
    logic [AW-1:0] eng_addr_a;
    logic [AW-1:0] eng_addr_b;
    logic [AW-1:0] eng_addr_out;
    logic [31:0]   eng_len;
    logic          eng_done;
    logic          cpl_valid;
    logic          cpl_ready = 1'b1;
    logic [TW-1:0] cpl_tag;
    logic [1:0]    cpl_err;
    logic          busy;
    logic [$clog2(D):0] count;

    logic model_done = 1'b0;
    logic stray_done = 1'b0;
    int   eng_delay = 3;

    assign eng_done = model_done | stray_done;

    typedef struct {
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic [AW-1:0] o;
        logic [31:0]   len;
    } start_exp_t;

    typedef struct {
        logic [TW-1:0] tag;
        logic [1:0]    err;
    } cpl_exp_t;

    start_exp_t start_q[$];
    cpl_exp_t   cpl_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_starts = 0;

    vadd_cmd_sched #(
        .ADDR_WIDTH (AW),
        .DEPTH      (D),
        .TAG_WIDTH  (TW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_addr_a   (cmd_addr_a),
        .cmd_addr_b   (cmd_addr_b),
        .cmd_addr_out (cmd_addr_out),
        .cmd_len      (cmd_len),
        .cmd_tag      (cmd_tag),
        .eng_start    (eng_start),
        .eng_addr_a   (eng_addr_a),
        .eng_addr_b   (eng_addr_b),
        .eng_addr_out (eng_addr_out),
        .eng_len      (eng_len),
        .eng_done     (eng_done),
        .cpl_valid    (cpl_valid),
        .cpl_ready    (cpl_ready),
        .cpl_tag      (cpl_tag),
        .cpl_err      (cpl_err),
        .busy         (busy),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_start(input logic [AW-1:0] a, input logic [AW-1:0] b,
                             input logic [AW-1:0] o, input logic [31:0] len);
        start_exp_t e;
        e.a = a;
        e.b = b;
        e.o = o;
        e.len = len;
        start_q.push_back(e);
    endtask

    task automatic exp_cpl(input logic [TW-1:0] tag, input logic [1:0] err);
        cpl_exp_t e;
        e.tag = tag;
        e.err = err;
        cpl_q.push_back(e);
    endtask

    always @(negedge clk) begin
        start_exp_t e;
        if (!rst && eng_start) begin
            n_starts++;
            if (start_q.size() == 0) begin
                chk("unexpected eng_start", 64'(eng_start), 64'd0);
            end else begin
                e = start_q.pop_front();
                chk("eng_addr_a", 64'(eng_addr_a), 64'(e.a));
                chk("eng_addr_b", 64'(eng_addr_b), 64'(e.b));
                chk("eng_addr_out", 64'(eng_addr_out), 64'(e.o));
                chk("eng_len", 64'(eng_len), 64'(e.len));
            end
        end
    end

    always @(negedge clk) begin
        cpl_exp_t e;
        if (!rst && cpl_valid && cpl_ready) begin
            if (cpl_q.size() == 0) begin
                chk("unexpected cpl", 64'(cpl_valid), 64'd0);
            end else begin
                e = cpl_q.pop_front();
                chk("cpl_tag", 64'(cpl_tag), 64'(e.tag));
                chk("cpl_err", 64'(cpl_err), 64'(e.err));
            end
        end
    end

    // engine model: one done pulse eng_delay cycles after each start
    initial begin
        forever begin
            @(negedge clk);
            if (eng_start) begin
                repeat (eng_delay) @(posedge clk);
                #1 model_done = 1'b1;
                @(posedge clk);
                #1 model_done = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // call at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [AW-1:0] a, input logic [AW-1:0] b,
                        input logic [AW-1:0] o, input logic [31:0] len,
                        input logic [TW-1:0] tag);
        int n = 0;
        cmd_valid    = 1'b1;
        cmd_addr_a   = a;
        cmd_addr_b   = b;
        cmd_addr_out = o;
        cmd_len      = len;
        cmd_tag      = tag;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("cmd_ready timeout", 64'(cmd_ready), 64'd1);
        sync();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while ((busy || count != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(busy), 64'd0);
    endtask

    initial begin
        int s0;
        int bad;
        int n;

        repeat (2) @(negedge clk);
        chk("rst cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst count", 64'(count), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst cpl_valid", 64'(cpl_valid), 64'd0);
        chk("rst eng_start", 64'(eng_start), 64'd0);
        chk("rst eng_len", 64'(eng_len), 64'd0);
        chk("rst cpl_tag", 64'(cpl_tag), 64'd0);
        chk("rst cpl_err", 64'(cpl_err), 64'd0);
        sync();
        rst = 1'b0;

        // basic command and start latency
        eng_delay = 3;
        exp_start(13'd0, 13'd16, 13'd32, 32'd8);
        exp_cpl(4'd5, 2'd0);
        send(13'd0, 13'd16, 13'd32, 32'd8, 4'd5);
        @(negedge clk);
        chk("start lat +1", 64'(eng_start), 64'd0);
        @(negedge clk);
        chk("start lat +2 pre", 64'(eng_start), 64'd0);
        @(negedge clk);
        chk("start lat 2", 64'(eng_start), 64'd1);
        wait_idle("idle after A");

        // zero length
        s0 = n_starts;
        exp_cpl(4'd3, 2'd1);
        sync();
        send(13'd100, 13'd200, 13'd300, 32'd0, 4'd3);
        wait_idle("idle after len0");
        chk("len0 no start", 64'(n_starts), 64'(s0));

        // range errors and the exact-fit boundary
        s0 = n_starts;
        exp_cpl(4'd6, 2'd2);
        exp_start(13'd8188, 13'd0, 13'd0, 32'd4);
        exp_cpl(4'd7, 2'd0);
        exp_cpl(4'd9, 2'd2);
        sync();
        send(13'd8190, 13'd0, 13'd0, 32'd4, 4'd6);
        send(13'd8188, 13'd0, 13'd0, 32'd4, 4'd7);
        send(13'd0, 13'd0, 13'd8000, 32'd200, 4'd9);
        wait_idle("idle after range");
        chk("range starts", 64'(n_starts), 64'(s0 + 1));

        // fill the queue behind a slow engine
        eng_delay = 30;
        sync();
        for (int i = 0; i < 5; i++) begin
            exp_start(13'(i * 16), 13'(i * 16 + 1), 13'(i * 16 + 2),
                      32'(10 + i));
            exp_cpl(4'(i), 2'd0);
            send(13'(i * 16), 13'(i * 16 + 1), 13'(i * 16 + 2),
                 32'(10 + i), 4'(i));
        end
        @(negedge clk);
        chk("full count", 64'(count), 64'd4);
        chk("full cmd_ready", 64'(cmd_ready), 64'd0);
        cmd_tag   = 4'd15;
        cmd_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("full ignore count", 64'(count), 64'd4);
        cmd_valid = 1'b0;
        wait_idle("idle after fill");

        // completion backpressure
        eng_delay = 2;
        cpl_ready = 1'b0;
        exp_start(13'h40, 13'h41, 13'h42, 32'd5);
        exp_cpl(4'd10, 2'd0);
        exp_start(13'h50, 13'h51, 13'h52, 32'd6);
        exp_cpl(4'd11, 2'd0);
        sync();
        send(13'h40, 13'h41, 13'h42, 32'd5, 4'd10);
        send(13'h50, 13'h51, 13'h52, 32'd6, 4'd11);
        n = 0;
        @(negedge clk);
        while (!cpl_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp cpl_valid", 64'(cpl_valid), 64'd1);
        s0  = n_starts;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (cpl_valid !== 1'b1 || cpl_tag !== 4'd10 ||
                cpl_err !== 2'd0 || eng_start !== 1'b0) bad++;
        end
        chk("bp stable cycles", 64'(bad), 64'd0);
        chk("bp no start", 64'(n_starts), 64'(s0));
        chk("bp count", 64'(count), 64'd1);
        sync();
        cpl_ready = 1'b1;
        wait_idle("idle after bp");

        // stray done while idle
        sync();
        stray_done = 1'b1;
        sync();
        stray_done = 1'b0;
        @(negedge clk);
        chk("stray busy", 64'(busy), 64'd0);
        chk("stray cpl_valid", 64'(cpl_valid), 64'd0);

        // reset during WAIT_DONE with two queued
        eng_delay = 50;
        exp_start(13'd1, 13'd2, 13'd3, 32'd1);
        sync();
        send(13'd1, 13'd2, 13'd3, 32'd1, 4'd12);
        send(13'd4, 13'd5, 13'd6, 32'd1, 4'd13);
        send(13'd7, 13'd8, 13'd9, 32'd1, 4'd14);
        repeat (3) @(negedge clk);
        chk("pre-rst count", 64'(count), 64'd2);
        chk("pre-rst busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst count now", 64'(count), 64'd0);
        chk("rst cpl_valid now", 64'(cpl_valid), 64'd0);
        chk("rst busy now", 64'(busy), 64'd0);
        chk("rst cmd_ready now", 64'(cmd_ready), 64'd1);
        chk("rst eng_len now", 64'(eng_len), 64'd0);
        sync();
        sync();
        rst = 1'b0;
        repeat (70) @(negedge clk);
        chk("post-rst busy", 64'(busy), 64'd0);
        chk("cpl left over", 64'(cpl_q.size()), 64'd0);
        chk("start left over", 64'(start_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
